// File: rtl/regfile_wb_queue_pkg.sv
// Shared constants for the register-file write-back queue: default widths,
// the zero word, the register-0 address and the write-enable levels.
package regfile_wb_queue_pkg;

    localparam int WBQ_DEPTH = 4;
    localparam int WBQ_AW    = 5;
    localparam int WBQ_DW    = 32;

    localparam logic [WBQ_DW-1:0] ZERO_WORD = '0;
    localparam logic [WBQ_AW-1:0] REG_ZERO  = '0;

    localparam logic WE_ON  = 1'b1;
    localparam logic WE_OFF = 1'b0;

endpackage

// File: rtl/regfile_wb_queue_fifo.sv
// In-order write-back FIFO: two ordered pushes (A then B) and one pop per cycle.
// Entry valid bits and addresses are exposed for the decode-stage hazard compare.
module wbq_fifo
    import regfile_wb_queue_pkg::*;
#(
    parameter  int DEPTH = WBQ_DEPTH,
    parameter  int AW    = WBQ_AW,
    parameter  int DW    = WBQ_DW,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_a,
    input  logic [AW-1:0]            push_a_addr,
    input  logic [DW-1:0]            push_a_data,
    input  logic                     push_b,
    input  logic [AW-1:0]            push_b_addr,
    input  logic [DW-1:0]            push_b_data,
    input  logic                     pop,
    output logic [AW-1:0]            head_addr,
    output logic [DW-1:0]            head_data,
    output logic [CW-1:0]            count,
    output logic [DEPTH-1:0]         entry_valid,
    output logic [DEPTH-1:0][AW-1:0] entry_addr
);

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [PW-1:0] b_slot;

    // B lands behind A when both push in the same cycle.
    assign b_slot = push_a ? wr_ptr_reg + PW'(1) : wr_ptr_reg;

    always_ff @(posedge clk) begin
        if (push_a) begin
            addr_mem[wr_ptr_reg] <= push_a_addr;
            data_mem[wr_ptr_reg] <= push_a_data;
        end
        if (push_b) begin
            addr_mem[b_slot] <= push_b_addr;
            data_mem[b_slot] <= push_b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PW'(push_a) + PW'(push_b);
            rd_ptr_reg <= rd_ptr_reg + PW'(pop);
            count_reg  <= count_reg + CW'(push_a) + CW'(push_b) - CW'(pop);
        end
    end

    assign head_addr = addr_mem[rd_ptr_reg];
    assign head_data = data_mem[rd_ptr_reg];
    assign count     = count_reg;

    // A slot is live when its distance from the read pointer is below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [PW-1:0] offset;
        assign offset          = PW'(gi) - rd_ptr_reg;
        assign entry_valid[gi] = ({1'b0, offset} < count_reg);
        assign entry_addr[gi]  = addr_mem[gi];
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Register-file write-back queue: arbitrates ALU (A) and load (B) results into an
// ordered FIFO, drains one write per cycle and flags pending RAW hazards.
// Optional same-cycle bypass into an empty queue when WB_QUEUE_BYPASS_EN is defined.
module regfile_wb_queue
    import regfile_wb_queue_pkg::*;
#(
    parameter  int DEPTH = WBQ_DEPTH,
    parameter  int AW    = WBQ_AW,
    parameter  int DW    = WBQ_DW,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    input  logic          hold,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    input  logic [AW-1:0] q_addr1,
    output logic          q_pend1,
    input  logic [AW-1:0] q_addr2,
    output logic          q_pend2,
    output logic [CW-1:0] count
);

    logic                     a_fire, b_fire;
    logic                     a_nz, b_nz;
    logic                     byp_a, byp_b;
    logic                     push_a, push_b;
    logic                     empty, pop;
    logic [AW-1:0]            head_addr;
    logic [DW-1:0]            head_data;
    logic [DEPTH-1:0]         entry_valid;
    logic [DEPTH-1:0][AW-1:0] entry_addr;
    logic [DEPTH-1:0]         hit1, hit2;

    logic                     we_reg;
    logic [AW-1:0]            waddr_reg;
    logic [DW-1:0]            wdata_reg;

    // Readiness looks only at the registered occupancy; a pop this cycle gives no credit.
    assign a_ready = !rst && (count < CW'(DEPTH));
    assign a_fire  = a_valid && a_ready;
    assign b_ready = !rst && ((count + CW'(a_fire)) < CW'(DEPTH));
    assign b_fire  = b_valid && b_ready;

    assign a_nz  = (a_addr != AW'(REG_ZERO));
    assign b_nz  = (b_addr != AW'(REG_ZERO));
    assign empty = (count == '0);
    assign pop   = !hold && !empty;

`ifdef WB_QUEUE_BYPASS_EN
    logic byp_ok;
    assign byp_ok = empty && !hold;
    assign byp_a  = byp_ok && a_fire && a_nz;
    assign byp_b  = byp_ok && b_fire && b_nz && !byp_a;
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    // Register-0 results complete the handshake but are dropped here.
    assign push_a = a_fire && a_nz && !byp_a;
    assign push_b = b_fire && b_nz && !byp_b;

    wbq_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_a      (push_a),
        .push_a_addr (a_addr),
        .push_a_data (a_data),
        .push_b      (push_b),
        .push_b_addr (b_addr),
        .push_b_data (b_data),
        .pop         (pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            we_reg    <= WE_OFF;
            waddr_reg <= AW'(REG_ZERO);
            wdata_reg <= DW'(ZERO_WORD);
        end else begin
            we_reg <= pop ? WE_ON : WE_OFF;
            if (pop) begin
                waddr_reg <= head_addr;
                wdata_reg <= head_data;
            end else if (byp_a || byp_b) begin
                waddr_reg <= waddr;
                wdata_reg <= wdata;
            end
        end
    end

    assign we    = we_reg || byp_a || byp_b;
    assign waddr = byp_a ? a_addr : (byp_b ? b_addr : waddr_reg);
    assign wdata = byp_a ? a_data : (byp_b ? b_data : wdata_reg);

    // A write is pending while queued or while it sits on the regfile port this cycle.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        assign hit1[gi] = entry_valid[gi] && (entry_addr[gi] == q_addr1);
        assign hit2[gi] = entry_valid[gi] && (entry_addr[gi] == q_addr2);
    end

    assign q_pend1 = (q_addr1 != AW'(REG_ZERO)) && ((|hit1) || (we && (waddr == q_addr1)));
    assign q_pend2 = (q_addr2 != AW'(REG_ZERO)) && ((|hit2) || (we && (waddr == q_addr2)));

endmodule
